// File: rtl/responder_pkg.sv
// Shared types and the priority-select helper for the buzz-in responder.
package responder_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED, TIMEOUT} state_t;
  typedef logic [3:0] bcd_t;

  localparam int MAX_PLAYERS = 15;

  // One-hot grant: first request found scanning upward from ptr, wrapping at n.
  function automatic logic [MAX_PLAYERS-1:0] rr_select(
    input logic [MAX_PLAYERS-1:0] req,
    input logic [3:0]             ptr,
    input int                     n
  );
    logic [MAX_PLAYERS-1:0] gnt;
    logic [4:0]             sum;
    logic [3:0]             idx;
    logic                   found;
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_PLAYERS; k++) begin
      sum = {1'b0, ptr} + 5'(k);
      if (sum >= 5'(n)) sum = sum - 5'(n);
      idx = sum[3:0];
      if (k < n && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/quiz_arbiter_if.sv
// Host/player/display bundle of the quiz arbiter.
interface quiz_arbiter_if #(
  parameter int N_PLAYERS = 4,
  parameter int SCORE_W   = 4
);
  logic                           Start;
  logic [N_PLAYERS-1:0]           Key_In;
  logic                           Judge_Valid;
  logic                           Judge_Correct;
  logic [N_PLAYERS-1:0]           LED_Out;
  logic [3:0]                     Player_Number;
  logic [3:0]                     TimerH;
  logic [3:0]                     TimerL;
  logic                           Buzz_Grant;
  logic                           Buzz_TimeOver;
  logic                           LED_OverTime;
  logic [N_PLAYERS-1:0]           Foul_Out;
  logic                           Round_Over;
  logic [N_PLAYERS*SCORE_W-1:0]   Score_Out;

  modport master (
    output Start, Key_In, Judge_Valid, Judge_Correct,
    input  LED_Out, Player_Number, TimerH, TimerL, Buzz_Grant, Buzz_TimeOver,
           LED_OverTime, Foul_Out, Round_Over, Score_Out
  );

  modport slave (
    input  Start, Key_In, Judge_Valid, Judge_Correct,
    output LED_Out, Player_Number, TimerH, TimerL, Buzz_Grant, Buzz_TimeOver,
           LED_OverTime, Foul_Out, Round_Over, Score_Out
  );
endinterface

// File: rtl/bcd_countdown.sv
// Loadable two-digit BCD seconds counter with its own per-second prescaler.
module bcd_countdown
  import responder_pkg::*;
#(
  parameter int LOAD         = 30,
  parameter int CLKS_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output bcd_t tens,
  output bcd_t ones,
  output logic zero,
  output logic expire
);
  localparam int   PW     = $clog2(CLKS_PER_SEC);
  localparam bcd_t LOAD_H = bcd_t'(LOAD / 10);
  localparam bcd_t LOAD_L = bcd_t'(LOAD % 10);

  logic [PW-1:0] pre;
  logic          step;

  assign step   = en && (pre == PW'(CLKS_PER_SEC - 1));
  assign zero   = (tens == 4'd0) && (ones == 4'd0);
  // Asserted on the edge that turns 01 into 00, so the owner can react in step.
  assign expire = step && (tens == 4'd0) && (ones == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tens <= '0;
      ones <= '0;
      pre  <= '0;
    end else if (load) begin
      tens <= LOAD_H;
      ones <= LOAD_L;
      pre  <= '0;
    end else if (en) begin
      if (step) begin
        pre <= '0;
        if (!zero) begin
          if (ones == 4'd0) begin
            ones <= 4'd9;
            tens <= tens - 4'd1;
          end else begin
            ones <= ones - 4'd1;
          end
        end
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: rtl/quiz_arbiter.sv
// N-player buzz-in controller: edge detect, arbitration, fouls, lockout,
// answer countdown and saturating scores.
module quiz_arbiter
  import responder_pkg::*;
#(
  parameter int N_PLAYERS    = 4,
  parameter int SCORE_W      = 4,
  parameter int ANSWER_SECS  = 30,
  parameter int CLKS_PER_SEC = 50_000_000,
  parameter int ARB_MODE     = 0
) (
  input  logic                CLK,
  input  logic                RSTn,
  quiz_arbiter_if.slave       bus
);
  state_t                              state;
  logic [N_PLAYERS-1:0]                key_s, key_d, edges, elig;
  logic [N_PLAYERS-1:0]                lockout, lock_nxt, foul, led, win_oh;
  logic [N_PLAYERS-1:0][SCORE_W-1:0]   score;
  logic [3:0]                          pnum, ptr, ptr_nxt, win_idx;
  logic [MAX_PLAYERS-1:0]              req_ext, sel_ext;
  logic                                grant_p, tov_p, ovt, rov_p, grant;
  logic                                tmr_load, tmr_en, tmr_zero, tmr_expire;
  bcd_t                                tmr_h, tmr_l;

  // Keys are registered once, then edge-detected against the prior sample.
  assign edges    = key_s & ~key_d;
  assign elig     = edges & ~lockout & ~foul;
  assign lock_nxt = lockout | led;

  always_comb begin
    req_ext                = '0;
    req_ext[N_PLAYERS-1:0] = elig;
  end

  assign sel_ext = rr_select(req_ext, (ARB_MODE != 0) ? ptr : 4'd0, N_PLAYERS);

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < MAX_PLAYERS; i++)
      if (sel_ext[i]) win_idx = 4'(i);
  end

  assign win_oh  = {{(N_PLAYERS-1){1'b0}}, 1'b1} << win_idx;
  assign ptr_nxt = (win_idx == 4'(N_PLAYERS - 1)) ? 4'd0 : win_idx + 4'd1;

  assign grant    = !bus.Start && (state == ARMED) && (|elig);
  assign tmr_load = bus.Start || grant;
  assign tmr_en   = (state == LOCKED) && !tmr_zero;

  bcd_countdown #(
    .LOAD         (ANSWER_SECS),
    .CLKS_PER_SEC (CLKS_PER_SEC)
  ) u_countdown (
    .clk    (CLK),
    .rst_n  (RSTn),
    .load   (tmr_load),
    .en     (tmr_en),
    .tens   (tmr_h),
    .ones   (tmr_l),
    .zero   (tmr_zero),
    .expire (tmr_expire)
  );

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= IDLE;
      key_s   <= '0;
      key_d   <= '0;
      lockout <= '0;
      foul    <= '0;
      led     <= '0;
      pnum    <= '0;
      ptr     <= '0;
      score   <= '0;
      grant_p <= 1'b0;
      tov_p   <= 1'b0;
      ovt     <= 1'b0;
      rov_p   <= 1'b0;
    end else begin
      key_s   <= bus.Key_In;
      key_d   <= key_s;
      grant_p <= 1'b0;
      tov_p   <= 1'b0;
      rov_p   <= 1'b0;
      if (bus.Start) begin
        lockout <= '0;
        led     <= '0;
        pnum    <= '0;
        ovt     <= 1'b0;
        state   <= ARMED;
      end else begin
        case (state)
          IDLE: foul <= foul | edges;
          ARMED: begin
            if (|elig) begin
              led     <= win_oh;
              pnum    <= win_idx + 4'd1;
              ptr     <= ptr_nxt;
              grant_p <= 1'b1;
              state   <= LOCKED;
            end
          end
          LOCKED: begin
            // A judgement on the expiry edge takes precedence over the timeout.
            if (bus.Judge_Valid) begin
              if (bus.Judge_Correct) begin
                for (int i = 0; i < N_PLAYERS; i++)
                  if (led[i] && score[i] != '1) score[i] <= score[i] + SCORE_W'(1);
                rov_p <= 1'b1;
                state <= IDLE;
              end else begin
                lockout <= lock_nxt;
                led     <= '0;
                pnum    <= '0;
                if (&(lock_nxt | foul)) begin
                  rov_p <= 1'b1;
                  state <= IDLE;
                end else begin
                  state <= ARMED;
                end
              end
            end else if (tmr_expire) begin
              tov_p <= 1'b1;
              rov_p <= 1'b1;
              ovt   <= 1'b1;
              state <= TIMEOUT;
            end
          end
          TIMEOUT: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.LED_Out       = led;
  assign bus.Player_Number = pnum;
  assign bus.TimerH        = tmr_h;
  assign bus.TimerL        = tmr_l;
  assign bus.Buzz_Grant    = grant_p;
  assign bus.Buzz_TimeOver = tov_p;
  assign bus.LED_OverTime  = ovt;
  assign bus.Foul_Out      = foul;
  assign bus.Round_Over    = rov_p;
  assign bus.Score_Out     = score;

endmodule

// File: tb/tb_quiz_arbiter.sv
// Two arbiters (fixed priority and round-robin) driven in lockstep, checked
// every cycle against a behavioural model plus directed literal expectations.
module tb_quiz_arbiter;
  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int ANS = 10;
  localparam int CPS = 4;

  logic         CLK  = 1'b0;
  logic         RSTn = 1'b0;
  logic         start = 1'b0, jv = 1'b0, jc = 1'b0;
  logic [N-1:0] key = '0;
  int           total = 0, bad = 0;

  always #5 CLK = ~CLK;

  quiz_arbiter_if #(.N_PLAYERS(N), .SCORE_W(SW)) bus0 ();
  quiz_arbiter_if #(.N_PLAYERS(N), .SCORE_W(SW)) bus1 ();

  assign bus0.Start = start;  assign bus0.Key_In = key;
  assign bus0.Judge_Valid = jv;  assign bus0.Judge_Correct = jc;
  assign bus1.Start = start;  assign bus1.Key_In = key;
  assign bus1.Judge_Valid = jv;  assign bus1.Judge_Correct = jc;

  quiz_arbiter #(.N_PLAYERS(N), .SCORE_W(SW), .ANSWER_SECS(ANS), .CLKS_PER_SEC(CPS), .ARB_MODE(0))
    dut0 (.CLK(CLK), .RSTn(RSTn), .bus(bus0));
  quiz_arbiter #(.N_PLAYERS(N), .SCORE_W(SW), .ANSWER_SECS(ANS), .CLKS_PER_SEC(CPS), .ARB_MODE(1))
    dut1 (.CLK(CLK), .RSTn(RSTn), .bus(bus1));

  // Model state per instance; state codes 0 idle, 1 armed, 2 locked, 3 timeout.
  int           m_st[2], m_pnum[2], m_ptr[2], m_rem[2], m_el[2];
  int           m_score[2][N];
  logic [N-1:0] m_lock[2], m_foul[2], m_led[2];
  logic         m_gp[2], m_tov[2], m_ovt[2], m_rov[2];
  logic [N-1:0] kh0, kh1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk2(input string nm, input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] e);
    chk({nm, ".fixed"}, a0, e);
    chk({nm, ".rr"}, a1, e);
  endtask

  task automatic m_reset();
    kh0 = '0; kh1 = '0;
    for (int m = 0; m < 2; m++) begin
      m_st[m] = 0; m_pnum[m] = 0; m_ptr[m] = 0; m_rem[m] = 0; m_el[m] = 0;
      m_lock[m] = '0; m_foul[m] = '0; m_led[m] = '0;
      m_gp[m] = 0; m_tov[m] = 0; m_ovt[m] = 0; m_rov[m] = 0;
      for (int i = 0; i < N; i++) m_score[m][i] = 0;
    end
  endtask

  task automatic m_step(input int m, input logic [N-1:0] ed);
    logic [N-1:0] el;
    int w, idx;
    m_gp[m] = 0; m_tov[m] = 0; m_rov[m] = 0;
    if (start) begin
      m_lock[m] = '0; m_rem[m] = ANS; m_el[m] = 0; m_led[m] = '0;
      m_pnum[m] = 0; m_ovt[m] = 0; m_st[m] = 1;
    end else begin
      case (m_st[m])
        0: m_foul[m] = m_foul[m] | ed;
        1: begin
          el = ed & ~m_lock[m] & ~m_foul[m];
          if (el != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
              idx = ((m == 1 ? m_ptr[m] : 0) + k) % N;
              if (w < 0 && el[idx]) w = idx;
            end
            m_ptr[m] = (w + 1) % N;
            m_led[m] = '0; m_led[m][w] = 1'b1;
            m_pnum[m] = w + 1; m_gp[m] = 1; m_rem[m] = ANS; m_el[m] = 0; m_st[m] = 2;
          end
        end
        2: begin
          m_el[m]++;
          m_rem[m] = ANS - m_el[m] / CPS;
          if (m_rem[m] < 0) m_rem[m] = 0;
          if (jv) begin
            if (jc) begin
              w = m_pnum[m] - 1;
              if (m_score[m][w] < (1 << SW) - 1) m_score[m][w]++;
              m_rov[m] = 1; m_st[m] = 0;
            end else begin
              m_lock[m] = m_lock[m] | m_led[m];
              m_led[m] = '0; m_pnum[m] = 0;
              if ((m_lock[m] | m_foul[m]) == {N{1'b1}}) begin
                m_rov[m] = 1; m_st[m] = 0;
              end else m_st[m] = 1;
            end
          end else if (m_rem[m] == 0) begin
            m_tov[m] = 1; m_rov[m] = 1; m_ovt[m] = 1; m_st[m] = 3;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic m_clock();
    logic [N-1:0] ed;
    ed = kh0 & ~kh1;
    kh1 = kh0;
    kh0 = key;
    m_step(0, ed);
    m_step(1, ed);
  endtask

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) m_reset();
    else m_clock();
  end

  task automatic cmp(input int m, input logic [N-1:0] led, input logic [3:0] pn,
                     input logic [3:0] th, input logic [3:0] tl, input logic bg,
                     input logic bt, input logic lo, input logic ro,
                     input logic [N-1:0] fo, input logic [N*SW-1:0] so);
    logic [N*SW-1:0] es;
    for (int i = 0; i < N; i++) es[i*SW +: SW] = SW'(m_score[m][i]);
    chk($sformatf("m%0d.led", m), 32'(led), 32'(m_led[m]));
    chk($sformatf("m%0d.pnum", m), 32'(pn), 32'(m_pnum[m]));
    chk($sformatf("m%0d.timer", m), {24'd0, th, tl},
        {24'd0, 4'(m_rem[m] / 10), 4'(m_rem[m] % 10)});
    chk($sformatf("m%0d.grant", m), 32'(bg), 32'(m_gp[m]));
    chk($sformatf("m%0d.timeover", m), 32'(bt), 32'(m_tov[m]));
    chk($sformatf("m%0d.overtime", m), 32'(lo), 32'(m_ovt[m]));
    chk($sformatf("m%0d.roundover", m), 32'(ro), 32'(m_rov[m]));
    chk($sformatf("m%0d.foul", m), 32'(fo), 32'(m_foul[m]));
    chk($sformatf("m%0d.score", m), 32'(so), 32'(es));
  endtask

  always @(negedge CLK) begin
    if (RSTn) begin
      cmp(0, bus0.LED_Out, bus0.Player_Number, bus0.TimerH, bus0.TimerL, bus0.Buzz_Grant,
          bus0.Buzz_TimeOver, bus0.LED_OverTime, bus0.Round_Over, bus0.Foul_Out, bus0.Score_Out);
      cmp(1, bus1.LED_Out, bus1.Player_Number, bus1.TimerH, bus1.TimerL, bus1.Buzz_Grant,
          bus1.Buzz_TimeOver, bus1.LED_OverTime, bus1.Round_Over, bus1.Foul_Out, bus1.Score_Out);
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic arm_and_press(input logic [N-1:0] k);
    key = '0; start = 1'b1; cyc(); start = 1'b0; key = k; cyc(2);
  endtask

  task automatic judge(input logic correct);
    jv = 1'b1; jc = correct; key = '0; cyc(); jv = 1'b0;
  endtask

  initial begin
    cyc(2);
    chk2("rst_pnum", bus0.Player_Number, bus1.Player_Number, 0);
    chk2("rst_led", bus0.LED_Out, bus1.LED_Out, 0);
    chk2("rst_timer", {bus0.TimerH, bus0.TimerL}, {bus1.TimerH, bus1.TimerL}, 0);
    chk2("rst_score", bus0.Score_Out, bus1.Score_Out, 0);
    RSTn = 1'b1;

    // Single press: two-cycle latency, timer loaded.
    start = 1'b1; cyc(); start = 1'b0; key = 4'b0100; cyc();
    chk2("lat_grant", bus0.Buzz_Grant, bus1.Buzz_Grant, 0);
    cyc();
    chk2("t1_pnum", bus0.Player_Number, bus1.Player_Number, 3);
    chk2("t1_led", bus0.LED_Out, bus1.LED_Out, 4'b0100);
    chk2("t1_grant", bus0.Buzz_Grant, bus1.Buzz_Grant, 1);
    chk2("t1_timer", {bus0.TimerH, bus0.TimerL}, {bus1.TimerH, bus1.TimerL}, 8'h10);
    judge(1'b1);
    chk2("t1_score", bus0.Score_Out, bus1.Score_Out, 8'h10);
    chk2("t1_rov", bus0.Round_Over, bus1.Round_Over, 1);

    // Arbitration: player 0 wins, then 0 and 1 press together.
    arm_and_press(4'b0001);
    chk2("t2a_pnum", bus0.Player_Number, bus1.Player_Number, 1);
    judge(1'b1);
    chk2("t2a_score", bus0.Score_Out, bus1.Score_Out, 8'h11);
    arm_and_press(4'b0011);
    chk("t2_fixed_pnum", 32'(bus0.Player_Number), 1);
    chk("t2_rr_pnum", 32'(bus1.Player_Number), 2);
    judge(1'b1);
    chk("t2_fixed_score", 32'(bus0.Score_Out), 8'h12);
    chk("t2_rr_score", 32'(bus1.Score_Out), 8'h15);

    // False start in idle, fouled player excluded next round.
    key = 4'b0100; cyc(2);
    chk2("t3_foul", bus0.Foul_Out, bus1.Foul_Out, 4'b0100);
    arm_and_press(4'b0100); cyc();
    chk2("t3_nogrant", bus0.Player_Number, bus1.Player_Number, 0);
    key = '0; cyc(); key = 4'b1000; cyc(2);
    chk2("t3_pnum", bus0.Player_Number, bus1.Player_Number, 4);

    // Wrong answers lock players out until nobody is left.
    judge(1'b0);
    chk2("t4_clear", bus0.Player_Number, bus1.Player_Number, 0);
    chk2("t4_rov0", bus0.Round_Over, bus1.Round_Over, 0);
    key = 4'b0010; cyc(2);
    chk2("t4_pnum1", bus0.Player_Number, bus1.Player_Number, 2);
    judge(1'b0);
    chk2("t4_rov1", bus0.Round_Over, bus1.Round_Over, 0);
    key = 4'b0001; cyc(2);
    chk2("t4_pnum0", bus0.Player_Number, bus1.Player_Number, 1);
    judge(1'b0);
    chk2("t4_rov2", bus0.Round_Over, bus1.Round_Over, 1);

    // Countdown and timeout.
    arm_and_press(4'b0001);
    chk2("t5_load", {bus0.TimerH, bus0.TimerL}, {bus1.TimerH, bus1.TimerL}, 8'h10);
    cyc(4);
    chk2("t5_09", {bus0.TimerH, bus0.TimerL}, {bus1.TimerH, bus1.TimerL}, 8'h09);
    cyc(36);
    chk2("t5_00", {bus0.TimerH, bus0.TimerL}, {bus1.TimerH, bus1.TimerL}, 8'h00);
    chk2("t5_tov", bus0.Buzz_TimeOver, bus1.Buzz_TimeOver, 1);
    chk2("t5_ovt", bus0.LED_OverTime, bus1.LED_OverTime, 1);
    cyc();
    chk2("t5_tov_pulse", bus0.Buzz_TimeOver, bus1.Buzz_TimeOver, 0);
    chk2("t5_ovt_hold", bus0.LED_OverTime, bus1.LED_OverTime, 1);

    // Judgement on the expiry edge beats the timeout.
    arm_and_press(4'b0001);
    cyc(39);
    judge(1'b1);
    chk2("t5j_tov", bus0.Buzz_TimeOver, bus1.Buzz_TimeOver, 0);
    chk2("t5j_ovt", bus0.LED_OverTime, bus1.LED_OverTime, 0);
    chk2("t5j_rov", bus0.Round_Over, bus1.Round_Over, 1);
    chk2("t5j_pnum", bus0.Player_Number, bus1.Player_Number, 1);

    // Score saturation.
    repeat (4) begin
      arm_and_press(4'b0001);
      judge(1'b1);
    end
    chk2("t6_sat", bus0.Score_Out[1:0], bus1.Score_Out[1:0], 3);

    // Asynchronous reset mid-answer.
    arm_and_press(4'b0001);
    chk2("t7_pnum", bus0.Player_Number, bus1.Player_Number, 1);
    #2 RSTn = 1'b0;
    #1;
    chk2("t7_pnum0", bus0.Player_Number, bus1.Player_Number, 0);
    chk2("t7_led0", bus0.LED_Out, bus1.LED_Out, 0);
    chk2("t7_score0", bus0.Score_Out, bus1.Score_Out, 0);
    chk2("t7_foul0", bus0.Foul_Out, bus1.Foul_Out, 0);
    chk2("t7_timer0", {bus0.TimerH, bus0.TimerL}, {bus1.TimerH, bus1.TimerL}, 0);
    @(negedge CLK); key = '0; RSTn = 1'b1;

    // Randomized traffic, with periodic resets to clear accumulated fouls.
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      start = ($urandom_range(0, 99) < 3);
      jv    = ($urandom_range(0, 99) < 5);
      jc    = 1'($urandom_range(0, 1));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 12) key[i] = ~key[i];
      if (c % 300 == 150) begin
        #2 RSTn = 1'b0;
        #1 chk2("rnd_rst_score", bus0.Score_Out, bus1.Score_Out, 0);
        @(negedge CLK); RSTn = 1'b1;
      end
    end
    start = 1'b0; jv = 1'b0; key = '0;
    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quiz_arbiter.md
# quiz_arbiter

Parametrised N-player buzz-in controller for the next-generation responder, replacing the fixed four-key selector/timer pair. It detects the first press after a round is armed, handles false starts, runs a BCD answer countdown, accepts a host judgement, keeps saturating per-player scores, and lets remaining players rebound after a wrong answer. Outputs feed the existing buzzer driver and the digit display multiplexer unchanged.

## Interface
- N_PLAYERS, 4: number of contestants, 2..15.
- SCORE_W, 4: score width per player; scores saturate at 2^SCORE_W-1.
- ANSWER_SECS, 30: countdown load value, 1..99.
- CLKS_PER_SEC, 50_000_000: CLK cycles per countdown step, ≥2.
- ARB_MODE, 0: 0 = fixed priority (lowest index wins); 1 = round-robin (priority starts one above the last winner).
- CLK  in  1  sole clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- Start  in  1  level, one-cycle pulse from host; arms or re-arms a round.
- Key_In  in  N_PLAYERS  debounced, synchronised player keys, active-high.
- Judge_Valid  in  1  one-cycle host judgement strobe.
- Judge_Correct  in  1  qualifies Judge_Valid: 1 correct, 0 wrong.
- LED_Out  out  N_PLAYERS  one-hot granted player.
- Player_Number  out  4  granted index+1; 0 = none.
- TimerH, TimerL  out  4 each  BCD remaining seconds.
- Buzz_Grant  out  1  one-cycle pulse on grant.
- Buzz_TimeOver  out  1  one-cycle pulse on countdown expiry.
- LED_OverTime  out  1  high in TIMEOUT until next Start.
- Foul_Out  out  N_PLAYERS  sticky false-start flags.
- Round_Over  out  1  one-cycle pulse when a round ends.
- Score_Out  out  N_PLAYERS*SCORE_W  packed scores, player 0 in LSBs.

## Operation
- States: IDLE, ARMED, LOCKED, TIMEOUT.
- Reset: IDLE; every output 0; scores, masks, round-robin pointer 0.
- Key edge = sampled Key_In high this cycle, low the previous cycle. Only edges are used.
- IDLE: key edge sets that player's Foul_Out bit (false start); no grant.
- Start (any state): clear lockout mask, load timer with ANSWER_SECS, clear LED_Out/Player_Number/LED_OverTime, go ARMED. Foul_Out is not cleared. Fouled players stay excluded for that round. Start in LOCKED aborts with no score change.
- ARMED: eligible = edges & ~lockout & ~Foul_Out. If eligible is nonzero, grant one player per ARB_MODE, go LOCKED, pulse Buzz_Grant, reload timer. Simultaneous edges resolve in the same cycle by the priority order. Timer is held in ARMED.
- LOCKED: countdown steps every CLKS_PER_SEC cycles, BCD borrow (x0 -> (x-1)9). Key edges are ignored.
- Judge correct: score+1 (saturating), pulse Round_Over, go IDLE. LED_Out and Player_Number are held.
- Judge wrong: set granted bit in lockout, clear grant, go ARMED. If all non-fouled players are now locked out, pulse Round_Over and go IDLE.
- Countdown reaching 00: pulse Buzz_TimeOver and Round_Over, set LED_OverTime, go TIMEOUT. Only Start leaves TIMEOUT.
- Judge_Valid outside LOCKED is ignored. Judge_Valid in the same cycle the count reaches 00: the judge wins and there is no timeout.
- The round-robin pointer updates on every grant. ARB_MODE=0 ignores it.

## Timing
- Key_In sampled high at edge n (low at n-1): LED_Out, Player_Number and Buzz_Grant are visible after edge n+1 (2-cycle latency).
- Judge_Valid sampled at edge n: score, state and Round_Over update after edge n.
- First countdown step occurs exactly CLKS_PER_SEC cycles after the grant edge. The prescaler is cleared on grant and on Start.
- Timeout pulse occurs ANSWER_SECS*CLKS_PER_SEC cycles after grant.
- Start has priority over every other event in the same cycle.
- Reset asserted mid-round takes effect immediately and asynchronously. It clears scores.

## Structure
- Shared package responder_pkg:
  - state enum;
  - BCD digit type;
  - round-robin priority-select function (one-hot grant from request vector and pointer).
- Sub-module bcd_countdown:
  - load value;
  - prescaler;
  - enable;
  - outputs TimerH/TimerL and a zero flag.
- Scoring, masks and the FSM stay in quiz_arbiter.

## Test plan
- Reset, Start, Key_In=4'b0100 -> after 2 cycles Player_Number=3, LED_Out=4'b0100, one Buzz_Grant, timer 30.
- ARB_MODE=1, player 0 wins and is judged correct. Start, then Key_In=4'b0011 simultaneously -> player 1 granted. With ARB_MODE=0 the same sequence grants player 0.
- Key 2 pressed in IDLE -> Foul_Out[2]=1. Start, then key 2 -> no grant. Key 3 -> grant 3.
- Grant player 1, Judge wrong -> back to ARMED, player 1 locked out. Player 0 presses -> grant 0. Judge wrong with players 2 and 3 fouled -> Round_Over, IDLE.
- CLKS_PER_SEC=4, ANSWER_SECS=10: grant -> 09 after 4 cycles, 00 after 40 cycles with Buzz_TimeOver, LED_OverTime=1. Judge in the zero cycle -> scored, no timeout.
- SCORE_W=2: four correct judgements for one player -> score stays 3. Assert RSTn low mid-LOCKED -> all outputs 0 immediately.
